// File: rtl/piccolo_spiflash_responder_pkg.sv
// Shared definitions for the EPCS-style SPI flash responder.
//   - Command codes of the supported read-only command subset.
//   - FSM state encoding used by the responder top.
//   - cmd_next_state(): maps a completed command byte to the FSM state that serves it.
package piccolo_spiflash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RES  = 8'hAB;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD      = 4'd1,
    ST_ADDR     = 4'd2,
    ST_DATA     = 4'd3,
    ST_ID_OUT   = 4'd4,
    ST_STAT_OUT = 4'd5,
    ST_DUMMY    = 4'd6,
    ST_SIG_OUT  = 4'd7,
    ST_IGNORE   = 4'd8
  } spi_state_e;

  // Decode a command byte into the state that handles the rest of the transfer.
  function automatic spi_state_e cmd_next_state(input logic [7:0] code);
    spi_state_e st;
    case (code)
      CMD_READ: st = ST_ADDR;
      CMD_RDID: st = ST_ID_OUT;
      CMD_RDSR: st = ST_STAT_OUT;
      CMD_RES:  st = ST_DUMMY;
      default:  st = ST_IGNORE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/piccolo_spiflash_responder_if.sv
// Bus bundle between the SPI flash responder and its surroundings.
//   SPI pins : spi_ss_n, spi_sck, spi_mosi (to responder), spi_miso, spi_miso_oe (from responder)
//   Memory   : mem_addr, mem_read (from responder), mem_readdata, mem_valid (to responder)
//   Monitor  : cmd_strobe, cmd_code (from responder)
// modport slave is the responder side; modport master is the SPI master / memory / bench side.
interface piccolo_spiflash_responder_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  spi_ss_n;
  logic                  spi_sck;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic [7:0]            mem_readdata;
  logic                  mem_valid;
  logic                  cmd_strobe;
  logic [7:0]            cmd_code;

  modport slave (
    input  spi_ss_n, spi_sck, spi_mosi, mem_readdata, mem_valid,
    output spi_miso, spi_miso_oe, mem_addr, mem_read, cmd_strobe, cmd_code
  );

  modport master (
    output spi_ss_n, spi_sck, spi_mosi, mem_readdata, mem_valid,
    input  spi_miso, spi_miso_oe, mem_addr, mem_read, cmd_strobe, cmd_code
  );
endinterface

// File: rtl/piccolo_spiflash_responder_sync.sv
// Input conditioning for the SPI slave: 2-FF synchronisers on ss_n, sck and mosi,
// plus a third sck stage for edge detection.
//   clk, reset          : system clock, async active-high reset
//   spi_ss_n/sck/mosi   : raw pins, asynchronous to clk
//   ss_active           : synchronised chip select asserted
//   sck_rise / sck_fall : one-clk pulses per detected SCK edge
//   mosi_s              : synchronised MOSI, aligned with sck_rise
module spi_slave_sync (
  input  logic clk,
  input  logic reset,
  input  logic spi_ss_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic ss_active,
  output logic sck_rise,
  output logic sck_fall,
  output logic mosi_s
);

  logic [1:0] ss_q;
  logic [1:0] sck_q;
  logic [1:0] mosi_q;
  logic       sck_dly_q;

  // Synchroniser chains; ss_n resets to the deselected level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ss_q      <= 2'b11;
      sck_q     <= 2'b00;
      mosi_q    <= 2'b00;
      sck_dly_q <= 1'b0;
    end else begin
      ss_q      <= {ss_q[0], spi_ss_n};
      sck_q     <= {sck_q[0], spi_sck};
      mosi_q    <= {mosi_q[0], spi_mosi};
      sck_dly_q <= sck_q[1];
    end
  end

  assign ss_active = ~ss_q[1];
  assign sck_rise  = sck_q[1] & ~sck_dly_q;
  assign sck_fall  = ~sck_q[1] & sck_dly_q;
  assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/piccolo_spiflash_responder.sv
// EPCS-style serial flash emulator (SPI mode 0 slave) serving READ, RDID, RDSR and RES
// from an external byte memory.
//   clk, reset : system clock (>= 16x SCK), async active-high reset
//   spi_mem    : SPI pins, byte-memory read port and command monitor (slave modport)
// MISO changes on detected SCK falling edges; a new byte is loaded at the falling edge
// that follows each completed byte, so its MSB is ready before the next rising edge.
module piccolo_spiflash_responder
  import piccolo_spiflash_pkg::*;
#(
  parameter int          ADDR_WIDTH = 24,
  parameter logic [23:0] JEDEC_ID   = 24'h20_20_15,
  parameter logic [7:0]  SIGNATURE  = 8'h14,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input logic                        clk,
  input logic                        reset,
  piccolo_spiflash_responder_if.slave spi_mem
);

  logic ss_active, sck_rise, sck_fall, mosi_s;

  spi_state_e            state_q, state_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;   // completed bytes since the command, saturating
  logic [22:0]           rx_sh_q, rx_sh_d;
  logic [7:0]            tx_sh_q, tx_sh_d;
  logic                  miso_q, miso_d, oe_q, oe_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_read_q, mem_read_d;
  logic [7:0]            buf_q, buf_d;             // prefetched memory byte
  logic                  buf_full_q, buf_full_d, rd_pend_q, rd_pend_d;
  logic                  cmd_strobe_q, cmd_strobe_d;
  logic [7:0]            cmd_code_q, cmd_code_d;

  logic [23:0] rx_next_s;
  logic        byte_done_s, cmd_done_s, hdr_done_s;
  logic [7:0]  tx_fill_s;

  spi_slave_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .spi_ss_n (spi_mem.spi_ss_n),
    .spi_sck  (spi_mem.spi_sck),
    .spi_mosi (spi_mem.spi_mosi),
    .ss_active(ss_active),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .mosi_s   (mosi_s)
  );

  assign rx_next_s   = {rx_sh_q, mosi_s};
  assign byte_done_s = sck_rise & (bit_cnt_q == 3'd7);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a deselected chip select wins over everything.
  always_comb begin
    state_d = state_q;
    if (!ss_active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_CMD;
        ST_CMD:   state_d = cmd_done_s ? cmd_next_state(rx_next_s[7:0]) : ST_CMD;
        ST_ADDR:  state_d = hdr_done_s ? ST_DATA : ST_ADDR;
        ST_DUMMY: state_d = hdr_done_s ? ST_SIG_OUT : ST_DUMMY;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs: phase-complete flags and the byte to load at the next byte boundary.
  always_comb begin
    cmd_done_s = 1'b0;
    hdr_done_s = 1'b0;
    tx_fill_s  = 8'h00;
    case (state_q)
      ST_CMD:             cmd_done_s = byte_done_s;
      ST_ADDR, ST_DUMMY:  hdr_done_s = byte_done_s & (byte_cnt_q == 2'd2);
      ST_DATA:            tx_fill_s  = buf_full_q ? buf_q : 8'hFF;  // late memory -> 0xFF
      ST_ID_OUT: begin
        case (byte_cnt_q)
          2'd0:    tx_fill_s = JEDEC_ID[23:16];
          2'd1:    tx_fill_s = JEDEC_ID[15:8];
          2'd2:    tx_fill_s = JEDEC_ID[7:0];
          default: tx_fill_s = 8'h00;
        endcase
      end
      ST_STAT_OUT:        tx_fill_s = STATUS_VAL;
      ST_SIG_OUT:         tx_fill_s = SIGNATURE;
      default:            tx_fill_s = 8'h00;
    endcase
  end

  // Datapath next-state: shifters, counters, memory port and command monitor.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    rx_sh_d      = rx_sh_q;
    tx_sh_d      = tx_sh_q;
    miso_d       = miso_q;
    oe_d         = oe_q;
    mem_addr_d   = mem_addr_q;
    mem_read_d   = 1'b0;
    buf_d        = buf_q;
    buf_full_d   = buf_full_q;
    rd_pend_d    = rd_pend_q;
    cmd_strobe_d = 1'b0;
    cmd_code_d   = cmd_code_q;
    if (!ss_active) begin
      // Deselect: abort the transfer without side effects and drop any pending read.
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 2'd0;
      tx_sh_d    = 8'h00;
      miso_d     = 1'b0;
      oe_d       = 1'b0;
      buf_full_d = 1'b0;
      rd_pend_d  = 1'b0;
    end else begin
      oe_d = 1'b1;
      if (sck_rise) begin
        rx_sh_d   = rx_next_s[22:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else begin
        rx_sh_d   = rx_sh_q;
        bit_cnt_d = bit_cnt_q;
      end
      if (cmd_done_s) begin
        byte_cnt_d   = 2'd0;
        cmd_strobe_d = 1'b1;
        cmd_code_d   = rx_next_s[7:0];
      end else if (byte_done_s && (byte_cnt_q != 2'd3)) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
      end else begin
        byte_cnt_d = byte_cnt_q;
      end
      if ((state_q == ST_DATA) && rd_pend_q && spi_mem.mem_valid) begin
        buf_d      = spi_mem.mem_readdata;
        buf_full_d = 1'b1;
        rd_pend_d  = 1'b0;
      end else begin
        buf_d = buf_q;
      end
      if (hdr_done_s && (state_q == ST_ADDR)) begin
        mem_addr_d = ADDR_WIDTH'(rx_next_s);   // upper address bits are dropped
        mem_read_d = 1'b1;
        rd_pend_d  = 1'b1;
        buf_full_d = 1'b0;
      end else begin
        mem_read_d = 1'b0;
      end
      if (sck_fall) begin
        if (bit_cnt_q == 3'd0) begin
          miso_d  = tx_fill_s[7];
          tx_sh_d = {tx_fill_s[6:0], 1'b0};
          if (state_q == ST_DATA) begin
            // Byte consumed: prefetch the next one a full byte-time ahead.
            buf_full_d = 1'b0;
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1'b1);
            mem_read_d = 1'b1;
            rd_pend_d  = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q;
          end
        end else begin
          miso_d  = tx_sh_q[7];
          tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
      end else begin
        miso_d  = miso_q;
        tx_sh_d = tx_sh_q;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 2'd0;
      rx_sh_q      <= 23'd0;
      tx_sh_q      <= 8'h00;
      miso_q       <= 1'b0;
      oe_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_read_q   <= 1'b0;
      buf_q        <= 8'h00;
      buf_full_q   <= 1'b0;
      rd_pend_q    <= 1'b0;
      cmd_strobe_q <= 1'b0;
      cmd_code_q   <= 8'h00;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      rx_sh_q      <= rx_sh_d;
      tx_sh_q      <= tx_sh_d;
      miso_q       <= miso_d;
      oe_q         <= oe_d;
      mem_addr_q   <= mem_addr_d;
      mem_read_q   <= mem_read_d;
      buf_q        <= buf_d;
      buf_full_q   <= buf_full_d;
      rd_pend_q    <= rd_pend_d;
      cmd_strobe_q <= cmd_strobe_d;
      cmd_code_q   <= cmd_code_d;
    end
  end

  assign spi_mem.spi_miso    = miso_q;
  assign spi_mem.spi_miso_oe = oe_q;
  assign spi_mem.mem_addr    = mem_addr_q;
  assign spi_mem.mem_read    = mem_read_q;
  assign spi_mem.cmd_strobe  = cmd_strobe_q;
  assign spi_mem.cmd_code    = cmd_code_q;

endmodule
